writeback_lanes: RTL and testbench
==================================

Name: writeback_lanes

Overview:
- Parametrised multi-lane writeback stage between the execute pipes and the active-list/bypass network.
- Each lane delays its writeback packet through DEPTH register stages.
- Each lane drives one control packet and one bypass from its last stage.
- On recovery, squashes only instructions younger than the recovering seqNo (wrap-aware); a full flush is also available.

Parameters:
NUM_LANES, 4, number of independent writeback lanes (1..8)
DEPTH, 1, register stages per lane (1..3)
SEQ_W, 8, sequence-number width
TAG_W, 7, physical destination tag width
DATA_W, 64, destination data width
AL_W, 7, active-list ID width
FLAGS_W, 8, flags width
BYP_FLAG_BIT, 4, flags bit that marks a register-writing instruction

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
recover_i  in  1  selective squash request this cycle
recoverSeqNo_i  in  SEQ_W  seqNo of recovering instruction
flushAll_i  in  1  unconditional flush of all lanes and stages
wbValid_i  in  NUM_LANES  per-lane input valid
wbSeqNo_i  in  NUM_LANES*SEQ_W  per-lane seqNo
wbPhyDest_i  in  NUM_LANES*TAG_W  per-lane destination tag
wbData_i  in  NUM_LANES*DATA_W  per-lane result
wbAlID_i  in  NUM_LANES*AL_W  per-lane active-list ID
wbFlags_i  in  NUM_LANES*FLAGS_W  per-lane flags
ctrlValid_o  out  NUM_LANES  control packet valid
ctrlSeqNo_o  out  NUM_LANES*SEQ_W  control seqNo
ctrlAlID_o  out  NUM_LANES*AL_W  control active-list ID
ctrlFlags_o  out  NUM_LANES*FLAGS_W  control flags
bypValid_o  out  NUM_LANES  bypass valid
bypTag_o  out  NUM_LANES*TAG_W  bypass tag
bypData_o  out  NUM_LANES*DATA_W  bypass data
wbCount_o  out  4  number of valid control packets this cycle (combinational popcount)

Behaviour:
- Reset (reset_n low, asynchronous): every stage register of every lane is cleared to 0. All outputs are therefore 0 while reset is held and until the first post-reset valid packet reaches the last stage.
- Latency: lane input to outputs is DEPTH cycles. Each lane advances every cycle; there is no stall and no backpressure.
- Invalid packets: when a stage is not valid, its payload is zeroed. Outputs with valid=0 therefore carry all-zero fields.
- ctrlValid_o[l] = last-stage valid of lane l.
- bypValid_o[l] = last-stage valid AND flags[BYP_FLAG_BIT].
- Younger test: diff = (s - recoverSeqNo_i) mod 2^SEQ_W. s is younger iff 1 <= diff <= 2^(SEQ_W-1)-1.
  - diff = 0: the recovering instruction itself is kept.
  - diff >= 2^(SEQ_W-1): treated as older and kept.
- Squash when recover_i=1: in the same clock edge, every stage whose next value (input or shifted) holds a younger seqNo is loaded as invalid/zero. The squash covers the lane-input capture.
- Flush when flushAll_i=1: every stage is loaded with zero, regardless of recover_i.
- Current-cycle outputs are not masked combinationally. Squash takes effect from the next edge.
- Simultaneous recover_i and a new younger input: the input is dropped. An older input or an equal-seqNo input is captured.
- wbCount_o: popcount of ctrlValid_o. Saturation is never needed (NUM_LANES <= 8 fits 4 bits).
- Reset asserted mid-pipeline: all in-flight packets are lost. There is no replay.

Optional Feature:
WB_SQUASH_CNT_EN
- Defined: adds output squashCnt_o, 16 bits. It increments by the number of valid stage entries killed by recover_i or flushAll_i in a cycle, and wraps modulo 2^16. Asynchronous reset sets it to 0.
- Not defined: port absent, no counter logic.

Decomposition:
- Package writeback_lanes_pkg holds:
  - localparam for the BYP_FLAG_BIT default
  - function is_younger(seq, ref, SEQ_W semantics as above)
  - typedef struct wb_stage_t {valid, seqNo, phyDest, data, alID, flags}
- Natural sub-module wb_lane_pipe: one lane, DEPTH stages, with its squash/flush logic and per-lane kill count. It is instantiated NUM_LANES times in a generate loop. The top level does the popcount and counter summing.

Test Plan:
1. Reset then idle: reset_n low 3 cycles, then high with wbValid_i=0. All outputs stay 0 and wbCount_o=0.
2. Latency, DEPTH=2: lane 1 valid with seqNo=0x10, tag=0x05, data=0xDEAD, flags=0x10. ctrlValid_o[1] and bypValid_o[1] go to 1 exactly 2 cycles later with bypTag_o=0x05 and bypData_o=0xDEAD. With flags=0x00, bypValid_o[1] stays 0 while ctrlValid_o[1]=1.
3. Selective squash, DEPTH=2: stages hold seqNos 0x20 and 0x22; recover_i=1 with recoverSeqNo_i=0x20. 0x22 is removed, 0x20 still emerges. A simultaneous input 0x21 is dropped and an input 0x1F is captured.
4. Wrap-around, SEQ_W=8: recoverSeqNo_i=0xFE. In-flight 0x01 is squashed (diff=3). In-flight 0x7F (diff=0x81) is kept.
5. Flush: flushAll_i=1 with all 4 lanes and all stages full. All outputs are 0 next cycle. With WB_SQUASH_CNT_EN and DEPTH=1, squashCnt_o increases by 4.
6. Async reset mid-flight: reset_n asserted between clock edges. Outputs clear immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/writeback_lanes_pkg.sv
// Shared types and helpers for the multi-lane writeback stage.
// Optional squash counter is enabled with WB_SQUASH_CNT_EN.
package writeback_lanes_pkg;

    localparam int unsigned BYP_FLAG_BIT_DEFAULT = 4;
    localparam int unsigned SEQ_W_DEFAULT        = 8;
    localparam int unsigned TAG_W_DEFAULT        = 7;
    localparam int unsigned DATA_W_DEFAULT       = 64;
    localparam int unsigned AL_W_DEFAULT         = 7;
    localparam int unsigned FLAGS_W_DEFAULT      = 8;

    // Stage layout at the default widths; lanes build the same layout at their own widths.
    typedef struct packed {
        logic                       valid;
        logic [SEQ_W_DEFAULT-1:0]   seq_no;
        logic [TAG_W_DEFAULT-1:0]   phy_dest;
        logic [DATA_W_DEFAULT-1:0]  data;
        logic [AL_W_DEFAULT-1:0]    al_id;
        logic [FLAGS_W_DEFAULT-1:0] flags;
    } wb_stage_t;

    // Wrap-aware age compare: younger iff 1 <= (seq - ref) mod 2^w <= 2^(w-1)-1.
    function automatic logic is_younger(input logic [31:0] seq, input logic [31:0] ref_seq,
                                        input int unsigned seq_w);
        logic [31:0] diff;
        logic [31:0] half;
        diff = (seq - ref_seq) & ((32'd1 << seq_w) - 32'd1);
        half = 32'd1 << (seq_w - 1);
        return (diff != '0) && (diff < half);
    endfunction

endpackage

// File: rtl/writeback_lanes_lane_pipe.sv
// One writeback lane: DEPTH register stages with selective squash and full flush.
// Exposes a per-lane kill count when WB_SQUASH_CNT_EN is defined.
module wb_lane_pipe
    import writeback_lanes_pkg::*;
#(
    parameter int unsigned DEPTH   = 1,
    parameter int unsigned SEQ_W   = SEQ_W_DEFAULT,
    parameter int unsigned TAG_W   = TAG_W_DEFAULT,
    parameter int unsigned DATA_W  = DATA_W_DEFAULT,
    parameter int unsigned AL_W    = AL_W_DEFAULT,
    parameter int unsigned FLAGS_W = FLAGS_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               recover,
    input  logic [SEQ_W-1:0]   recover_seq,
    input  logic               flush_all,
    input  logic               in_valid,
    input  logic [SEQ_W-1:0]   in_seq,
    input  logic [TAG_W-1:0]   in_tag,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [AL_W-1:0]    in_al,
    input  logic [FLAGS_W-1:0] in_flags,
`ifdef WB_SQUASH_CNT_EN
    output logic [1:0]         kill_cnt,
`endif
    output logic               out_valid,
    output logic [SEQ_W-1:0]   out_seq,
    output logic [TAG_W-1:0]   out_tag,
    output logic [DATA_W-1:0]  out_data,
    output logic [AL_W-1:0]    out_al,
    output logic [FLAGS_W-1:0] out_flags
);

    typedef struct packed {
        logic               valid;
        logic [SEQ_W-1:0]   seq_no;
        logic [TAG_W-1:0]   phy_dest;
        logic [DATA_W-1:0]  data;
        logic [AL_W-1:0]    al_id;
        logic [FLAGS_W-1:0] flags;
    } stage_t;

    stage_t stg_q [DEPTH];
    stage_t cand  [DEPTH];
    stage_t stg_d [DEPTH];
    logic   kill  [DEPTH];

    // Squash decisions are made on each stage's incoming value, so input capture is covered too.
    always_comb begin
        cand[0] = '0;
        if (in_valid) begin
            cand[0].valid    = 1'b1;
            cand[0].seq_no   = in_seq;
            cand[0].phy_dest = in_tag;
            cand[0].data     = in_data;
            cand[0].al_id    = in_al;
            cand[0].flags    = in_flags;
        end
        for (int unsigned i = 1; i < DEPTH; i++) begin
            cand[i] = stg_q[i-1];
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            kill[i]  = cand[i].valid &&
                       (flush_all || (recover &&
                        is_younger(32'(cand[i].seq_no), 32'(recover_seq), SEQ_W)));
            stg_d[i] = kill[i] ? '0 : cand[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) stg_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) stg_q[i] <= stg_d[i];
        end
    end

`ifdef WB_SQUASH_CNT_EN
    always_comb begin
        kill_cnt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (kill[i]) kill_cnt = kill_cnt + 2'd1;
        end
    end
`endif

    assign out_valid = stg_q[DEPTH-1].valid;
    assign out_seq   = stg_q[DEPTH-1].seq_no;
    assign out_tag   = stg_q[DEPTH-1].phy_dest;
    assign out_data  = stg_q[DEPTH-1].data;
    assign out_al    = stg_q[DEPTH-1].al_id;
    assign out_flags = stg_q[DEPTH-1].flags;

endmodule

// File: rtl/writeback_lanes.sv
// Multi-lane writeback stage: per-lane delay pipes, bypass qualification, valid popcount.
// Define WB_SQUASH_CNT_EN to add the 16-bit squashCnt_o kill counter.
module writeback_lanes
    import writeback_lanes_pkg::*;
#(
    parameter int unsigned NUM_LANES    = 4,
    parameter int unsigned DEPTH        = 1,
    parameter int unsigned SEQ_W        = SEQ_W_DEFAULT,
    parameter int unsigned TAG_W        = TAG_W_DEFAULT,
    parameter int unsigned DATA_W       = DATA_W_DEFAULT,
    parameter int unsigned AL_W         = AL_W_DEFAULT,
    parameter int unsigned FLAGS_W      = FLAGS_W_DEFAULT,
    parameter int unsigned BYP_FLAG_BIT = BYP_FLAG_BIT_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         recover_i,
    input  logic [SEQ_W-1:0]             recoverSeqNo_i,
    input  logic                         flushAll_i,
    input  logic [NUM_LANES-1:0]         wbValid_i,
    input  logic [NUM_LANES*SEQ_W-1:0]   wbSeqNo_i,
    input  logic [NUM_LANES*TAG_W-1:0]   wbPhyDest_i,
    input  logic [NUM_LANES*DATA_W-1:0]  wbData_i,
    input  logic [NUM_LANES*AL_W-1:0]    wbAlID_i,
    input  logic [NUM_LANES*FLAGS_W-1:0] wbFlags_i,
    output logic [NUM_LANES-1:0]         ctrlValid_o,
    output logic [NUM_LANES*SEQ_W-1:0]   ctrlSeqNo_o,
    output logic [NUM_LANES*AL_W-1:0]    ctrlAlID_o,
    output logic [NUM_LANES*FLAGS_W-1:0] ctrlFlags_o,
    output logic [NUM_LANES-1:0]         bypValid_o,
    output logic [NUM_LANES*TAG_W-1:0]   bypTag_o,
    output logic [NUM_LANES*DATA_W-1:0]  bypData_o,
`ifdef WB_SQUASH_CNT_EN
    output logic [15:0]                  squashCnt_o,
`endif
    output logic [3:0]                   wbCount_o
);

`ifdef WB_SQUASH_CNT_EN
    logic [1:0]  lane_kill [NUM_LANES];
    logic [15:0] kill_sum;
    logic [15:0] squash_cnt_q;
`endif

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        wb_lane_pipe #(
            .DEPTH   (DEPTH),
            .SEQ_W   (SEQ_W),
            .TAG_W   (TAG_W),
            .DATA_W  (DATA_W),
            .AL_W    (AL_W),
            .FLAGS_W (FLAGS_W)
        ) u_lane (
            .clk         (clk),
            .reset_n     (reset_n),
            .recover     (recover_i),
            .recover_seq (recoverSeqNo_i),
            .flush_all   (flushAll_i),
            .in_valid    (wbValid_i[l]),
            .in_seq      (wbSeqNo_i[l*SEQ_W +: SEQ_W]),
            .in_tag      (wbPhyDest_i[l*TAG_W +: TAG_W]),
            .in_data     (wbData_i[l*DATA_W +: DATA_W]),
            .in_al       (wbAlID_i[l*AL_W +: AL_W]),
            .in_flags    (wbFlags_i[l*FLAGS_W +: FLAGS_W]),
`ifdef WB_SQUASH_CNT_EN
            .kill_cnt    (lane_kill[l]),
`endif
            .out_valid   (ctrlValid_o[l]),
            .out_seq     (ctrlSeqNo_o[l*SEQ_W +: SEQ_W]),
            .out_tag     (bypTag_o[l*TAG_W +: TAG_W]),
            .out_data    (bypData_o[l*DATA_W +: DATA_W]),
            .out_al      (ctrlAlID_o[l*AL_W +: AL_W]),
            .out_flags   (ctrlFlags_o[l*FLAGS_W +: FLAGS_W])
        );

        assign bypValid_o[l] = ctrlValid_o[l] & ctrlFlags_o[l*FLAGS_W + BYP_FLAG_BIT];
    end

    always_comb begin
        wbCount_o = '0;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            wbCount_o = wbCount_o + 4'(ctrlValid_o[l]);
        end
    end

`ifdef WB_SQUASH_CNT_EN
    always_comb begin
        kill_sum = '0;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            kill_sum = kill_sum + 16'(lane_kill[l]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) squash_cnt_q <= '0;
        else          squash_cnt_q <= squash_cnt_q + kill_sum;
    end

    assign squashCnt_o = squash_cnt_q;
`endif

endmodule

// File: tb/tb_writeback_lanes.sv
// Directed bench for writeback_lanes (4 lanes, DEPTH=2); checks squashCnt_o when WB_SQUASH_CNT_EN is set.
module tb_writeback_lanes;

    localparam int unsigned NL = 4;
    localparam int unsigned D  = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          recover_i;
    logic [7:0]    recoverSeqNo_i;
    logic          flushAll_i;
    logic [NL-1:0] wbValid_i;
    logic [NL*8-1:0]  wbSeqNo_i;
    logic [NL*7-1:0]  wbPhyDest_i;
    logic [NL*64-1:0] wbData_i;
    logic [NL*7-1:0]  wbAlID_i;
    logic [NL*8-1:0]  wbFlags_i;
    logic [NL-1:0]    ctrlValid_o;
    logic [NL*8-1:0]  ctrlSeqNo_o;
    logic [NL*7-1:0]  ctrlAlID_o;
    logic [NL*8-1:0]  ctrlFlags_o;
    logic [NL-1:0]    bypValid_o;
    logic [NL*7-1:0]  bypTag_o;
    logic [NL*64-1:0] bypData_o;
    logic [3:0]       wbCount_o;
`ifdef WB_SQUASH_CNT_EN
    logic [15:0]      squashCnt_o;
    logic [15:0]      cnt_before;
`endif

    int n_pass  = 0;
    int n_total = 0;

    writeback_lanes #(
        .NUM_LANES    (NL),
        .DEPTH        (D),
        .SEQ_W        (8),
        .TAG_W        (7),
        .DATA_W       (64),
        .AL_W         (7),
        .FLAGS_W      (8),
        .BYP_FLAG_BIT (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .recover_i      (recover_i),
        .recoverSeqNo_i (recoverSeqNo_i),
        .flushAll_i     (flushAll_i),
        .wbValid_i      (wbValid_i),
        .wbSeqNo_i      (wbSeqNo_i),
        .wbPhyDest_i    (wbPhyDest_i),
        .wbData_i       (wbData_i),
        .wbAlID_i       (wbAlID_i),
        .wbFlags_i      (wbFlags_i),
        .ctrlValid_o    (ctrlValid_o),
        .ctrlSeqNo_o    (ctrlSeqNo_o),
        .ctrlAlID_o     (ctrlAlID_o),
        .ctrlFlags_o    (ctrlFlags_o),
        .bypValid_o     (bypValid_o),
        .bypTag_o       (bypTag_o),
        .bypData_o      (bypData_o),
`ifdef WB_SQUASH_CNT_EN
        .squashCnt_o    (squashCnt_o),
`endif
        .wbCount_o      (wbCount_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         lane;
        logic [7:0] seq;
        logic [6:0] tag;
        logic [63:0] data;
        logic [6:0] al;
        logic [7:0] flags;
        logic       exp_byp;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic clear_inputs();
        wbValid_i   = '0;
        wbSeqNo_i   = '0;
        wbPhyDest_i = '0;
        wbData_i    = '0;
        wbAlID_i    = '0;
        wbFlags_i   = '0;
    endtask

    task automatic drive_lane(input int l, input logic [7:0] seq, input logic [6:0] tag,
                              input logic [63:0] data, input logic [6:0] al,
                              input logic [7:0] flags);
        wbValid_i[l]          = 1'b1;
        wbSeqNo_i[l*8 +: 8]   = seq;
        wbPhyDest_i[l*7 +: 7] = tag;
        wbData_i[l*64 +: 64]  = data;
        wbAlID_i[l*7 +: 7]    = al;
        wbFlags_i[l*8 +: 8]   = flags;
    endtask

    task automatic check_idle(input string name);
        check({name, "_valid"}, 64'(ctrlValid_o), 64'd0);
        check({name, "_byp"},   64'(bypValid_o),  64'd0);
        check({name, "_count"}, 64'(wbCount_o),   64'd0);
        check({name, "_zero"},  64'({|ctrlSeqNo_o, |ctrlAlID_o, |ctrlFlags_o, |bypTag_o, |bypData_o}), 64'd0);
    endtask

    initial begin
        vecs[0] = '{1, 8'h10, 7'h05, 64'hDEAD,                 7'h11, 8'h10, 1'b1};
        vecs[1] = '{1, 8'h11, 7'h05, 64'hBEEF,                 7'h12, 8'h00, 1'b0};
        vecs[2] = '{0, 8'h30, 7'h7F, 64'hFFFF_FFFF_FFFF_FFFF,  7'h7F, 8'hFF, 1'b1};
        vecs[3] = '{3, 8'h44, 7'h2A, 64'h0123_4567_89AB_CDEF,  7'h01, 8'hEF, 1'b0};
        vecs[4] = '{2, 8'h80, 7'h01, 64'h1,                    7'h40, 8'h10, 1'b1};

        reset_n = 1'b0;
        recover_i = 1'b0;
        recoverSeqNo_i = '0;
        flushAll_i = 1'b0;
        clear_inputs();

        // reset held, then idle
        repeat (3) @(negedge clk);
        check_idle("rst_hold");
`ifdef WB_SQUASH_CNT_EN
        check("rst_cnt", 64'(squashCnt_o), 64'd0);
`endif
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("idle");

        // single packets, exact DEPTH-cycle latency
        for (int v = 0; v < 5; v++) begin
            drive_lane(vecs[v].lane, vecs[v].seq, vecs[v].tag, vecs[v].data, vecs[v].al, vecs[v].flags);
            @(negedge clk);
            clear_inputs();
            check("lat_early", 64'(ctrlValid_o), 64'd0);
            @(negedge clk);
            check("vec_valid", 64'(ctrlValid_o), 64'(1) << vecs[v].lane);
            check("vec_byp",   64'(bypValid_o),  64'(vecs[v].exp_byp) << vecs[v].lane);
            check("vec_seq",   64'(ctrlSeqNo_o[vecs[v].lane*8 +: 8]),  64'(vecs[v].seq));
            check("vec_tag",   64'(bypTag_o[vecs[v].lane*7 +: 7]),     64'(vecs[v].tag));
            check("vec_data",  bypData_o[vecs[v].lane*64 +: 64],       vecs[v].data);
            check("vec_al",    64'(ctrlAlID_o[vecs[v].lane*7 +: 7]),   64'(vecs[v].al));
            check("vec_flags", 64'(ctrlFlags_o[vecs[v].lane*8 +: 8]),  64'(vecs[v].flags));
            check("vec_count", 64'(wbCount_o), 64'd1);
        end
        @(negedge clk);
        check_idle("drain");

        // selective squash: 0x20 kept (equal), 0x22 removed, input 0x21 dropped, 0x1F captured
        drive_lane(0, 8'h20, 7'h01, 64'h20, 7'h01, 8'h10);
        drive_lane(3, 8'h22, 7'h03, 64'h22, 7'h03, 8'h10);
        @(negedge clk);
        clear_inputs();
        recover_i = 1'b1;
        recoverSeqNo_i = 8'h20;
        drive_lane(1, 8'h21, 7'h02, 64'h21, 7'h02, 8'h10);
        drive_lane(2, 8'h1F, 7'h04, 64'h1F, 7'h04, 8'h10);
        @(negedge clk);
        recover_i = 1'b0;
        clear_inputs();
        check("sq_valid", 64'(ctrlValid_o), 64'h1);
        check("sq_seq0",  64'(ctrlSeqNo_o[7:0]), 64'h20);
        check("sq_count", 64'(wbCount_o), 64'd1);
        @(negedge clk);
        check("sq_in_valid", 64'(ctrlValid_o), 64'h4);
        check("sq_in_seq",   64'(ctrlSeqNo_o[23:16]), 64'h1F);
        @(negedge clk);
        check_idle("sq_drain");

        // wrap-around around recoverSeqNo=0xFE, including both half-range boundaries
        drive_lane(0, 8'h01, 7'h01, 64'h1, 7'h01, 8'h00);
        drive_lane(1, 8'h7F, 7'h02, 64'h2, 7'h02, 8'h00);
        drive_lane(2, 8'h7D, 7'h03, 64'h3, 7'h03, 8'h00);
        drive_lane(3, 8'h7E, 7'h04, 64'h4, 7'h04, 8'h00);
        @(negedge clk);
        clear_inputs();
        recover_i = 1'b1;
        recoverSeqNo_i = 8'hFE;
        @(negedge clk);
        recover_i = 1'b0;
        check("wrap_valid", 64'(ctrlValid_o), 64'hA);
        check("wrap_count", 64'(wbCount_o), 64'd2);
        check("wrap_seq1",  64'(ctrlSeqNo_o[15:8]), 64'h7F);
        check("wrap_seq3",  64'(ctrlSeqNo_o[31:24]), 64'h7E);
        @(negedge clk);
        check_idle("wrap_drain");

        // flush with every lane and stage full plus valid inputs
        for (int l = 0; l < 4; l++) drive_lane(l, 8'(8'h50 + l), 7'(l), 64'(l), 7'(l), 8'h10);
        @(negedge clk);
        for (int l = 0; l < 4; l++) drive_lane(l, 8'(8'h54 + l), 7'(l), 64'(l), 7'(l), 8'h10);
        @(negedge clk);
        check("fl_full", 64'(ctrlValid_o), 64'hF);
        check("fl_full_count", 64'(wbCount_o), 64'd4);
        for (int l = 0; l < 4; l++) drive_lane(l, 8'(8'h58 + l), 7'(l), 64'(l), 7'(l), 8'h10);
        flushAll_i = 1'b1;
        recover_i = 1'b1;
        recoverSeqNo_i = 8'h00;
`ifdef WB_SQUASH_CNT_EN
        cnt_before = squashCnt_o;
`endif
        @(negedge clk);
        flushAll_i = 1'b0;
        recover_i = 1'b0;
        clear_inputs();
        check_idle("flush");
`ifdef WB_SQUASH_CNT_EN
        // four lane inputs plus four first-stage entries were dropped
        check("flush_cnt", 64'(squashCnt_o - cnt_before), 64'd8);
`endif
        @(negedge clk);
        check_idle("flush_next");

        // asynchronous reset between edges
        drive_lane(0, 8'h60, 7'h06, 64'h60, 7'h06, 8'h10);
        @(negedge clk);
        clear_inputs();
        drive_lane(1, 8'h61, 7'h07, 64'h61, 7'h07, 8'h10);
        @(negedge clk);
        clear_inputs();
        check("ar_before", 64'(ctrlValid_o), 64'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check_idle("ar_async");
`ifdef WB_SQUASH_CNT_EN
        check("ar_cnt", 64'(squashCnt_o), 64'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_idle("ar_lost");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
